// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus fabric: FSM states, error causes, size codes
// and the memory map of the six current slaves.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_UNMAPPED = 3'd1;
  localparam logic [2:0] ERR_MISALIGN = 3'd2;
  localparam logic [2:0] ERR_WPROT    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_RDWR     = 3'd5;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  // ROM, RAM, sysctrl, disk, USB, signal tap
  localparam logic [6*32-1:0] DEF_BASE = {
    32'h4003_0000, 32'h4002_0000, 32'h4001_0000,
    32'h4000_0000, 32'h1000_0000, 32'h0000_0000
  };
  localparam logic [6*32-1:0] DEF_MASK = {
    32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF,
    32'h0000_FFFF, 32'h0FFF_FFFF, 32'h0000_FFFF
  };
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  function automatic logic size_fault(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lsb[0];
      SIZE_WORD: return |lsb;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/bus_fabric_if.sv
// Master-side request/response and per-slave strobe bundle of the fabric.
// The fabric plugs in through the slave modport; the CPU/peripheral side uses master.
interface bus_fabric_if #(
  parameter int NUM_SLAVES = 6,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W-1:0]            m_wdata;
  logic [2:0]                   m_size;
  logic                         m_read;
  logic                         m_write;
  logic [DATA_W-1:0]            m_rdata;
  logic                         m_busy;
  logic                         m_error;
  logic [2:0]                   m_err_code;
  logic [NUM_SLAVES*ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [2:0]                   s_size;
  logic [NUM_SLAVES-1:0]        s_read;
  logic [NUM_SLAVES-1:0]        s_write;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]        s_ready;

  modport slave (
    input  m_addr, m_wdata, m_size, m_read, m_write, s_rdata, s_ready,
    output m_rdata, m_busy, m_error, m_err_code, s_addr, s_wdata, s_size, s_read, s_write
  );

  modport master (
    output m_addr, m_wdata, m_size, m_read, m_write, s_rdata, s_ready,
    input  m_rdata, m_busy, m_error, m_err_code, s_addr, s_wdata, s_size, s_read, s_write
  );
endinterface

// File: rtl/bus_addr_decoder.sv
// Combinational base/mask window decode; overlapping windows resolve to the lowest index.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = 6,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 3,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic                  any_hit,
  output logic [IDX_W-1:0]      sel
);
  logic [NUM_SLAVES-1:0] raw;

  always_comb begin
    raw = '0;
    hit = '0;
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      raw[i] = ((addr & ~SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLAVE_BASE[i*ADDR_W +: ADDR_W] & ~SLAVE_MASK[i*ADDR_W +: ADDR_W]));
    end
    // walk downwards so the lowest hitting index is the last one written
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (raw[i]) begin
        hit    = '0;
        hit[i] = 1'b1;
        sel    = IDX_W'(i);
      end
    end
  end

  assign any_hit = |raw;
endmodule

// File: rtl/bus_fabric.sv
// Single-master interconnect: decodes, strobes one slave until ready or timeout,
// then holds the response (data/error/cause) until the master drops its request.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = 6,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEF_MASK,
  parameter logic [NUM_SLAVES-1:0]        WR_ALLOW   = 6'b111110,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0]            ERR_DATA   = DEF_ERR_DATA
) (
  input logic        clk,
  input logic        rst_n,
  bus_fabric_if.slave bus
);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = 16;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [2:0]          size_q, code_q, fault_code;
  logic                wr_q, error_q;
  logic [IDX_W-1:0]    sel_q, dec_sel;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_SLAVES-1:0] dec_hit, sel_oh;
  logic                dec_any, req, ready_sel, cnt_done;

  bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .addr    (bus.m_addr),
    .hit     (dec_hit),
    .any_hit (dec_any),
    .sel     (dec_sel)
  );

  assign req       = bus.m_read | bus.m_write;
  assign ready_sel = bus.s_ready[sel_q];
  assign cnt_done  = (cnt == CNT_W'(TIMEOUT - 1));
  assign sel_oh    = NUM_SLAVES'(1) << sel_q;

  always_comb begin
    fault_code = ERR_NONE;
    if (bus.m_read && bus.m_write)                             fault_code = ERR_RDWR;
    else if (size_fault(bus.m_size, bus.m_addr[1:0]))          fault_code = ERR_MISALIGN;
    else if (!dec_any)                                         fault_code = ERR_UNMAPPED;
    else if (bus.m_write && |(dec_hit & ~WR_ALLOW))            fault_code = ERR_WPROT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req) state_nxt = (fault_code != ERR_NONE) ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (ready_sel || cnt_done) state_nxt = ST_RESP;
      ST_RESP:   if (!req) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.s_read  = '0;
    bus.s_write = '0;
    if (state == ST_ACCESS) begin
      if (wr_q) bus.s_write = sel_oh;
      else      bus.s_read  = sel_oh;
    end
    bus.m_busy = req && (state != ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      sel_q   <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          addr_q  <= bus.m_addr;
          wdata_q <= bus.m_wdata;
          size_q  <= bus.m_size;
          wr_q    <= bus.m_write;
          sel_q   <= dec_sel;
          cnt     <= '0;
          if (fault_code != ERR_NONE) begin
            rdata_q <= ERR_DATA;
            error_q <= 1'b1;
            code_q  <= fault_code;
          end
        end
        ST_ACCESS: begin
          if (ready_sel) begin
            rdata_q <= bus.s_rdata[int'(sel_q)*DATA_W +: DATA_W];
            error_q <= 1'b0;
            code_q  <= ERR_NONE;
          end else if (cnt_done) begin
            rdata_q <= ERR_DATA;
            error_q <= 1'b1;
            code_q  <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) bus.s_addr[i*ADDR_W +: ADDR_W] = addr_q & SLAVE_MASK[i*ADDR_W +: ADDR_W];
  end

  assign bus.s_wdata    = wdata_q;
  assign bus.s_size     = size_q;
  assign bus.m_rdata    = rdata_q;
  assign bus.m_error    = error_q;
  assign bus.m_err_code = code_q;
endmodule

// File: tb/tb_bus_fabric.sv
// Two fabrics (default 6-slave map with short timeout, 8-slave overlapping map)
// driven by directed and random transactions against an address-range reference model.
module tb_bus_fabric;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam int TO_A = 16;
  localparam int TO_B = 255;
  localparam logic [8*32-1:0] B_BASE = {
    32'h6000_0000, 32'h5000_0000, 32'h4003_0000, 32'h4002_0000,
    32'h4001_0000, 32'h4000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [8*32-1:0] B_MASK = {
    32'h0000_0FFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF,
    32'h0000_FFFF, 32'h0001_FFFF, 32'h0FFF_FFFF, 32'h0000_FFFF};

  // independent copy of both memory maps: [config][slave]
  localparam logic [31:0] BASE_T [2][8] = '{
    '{32'h0000_0000, 32'h1000_0000, 32'h4000_0000, 32'h4001_0000,
      32'h4002_0000, 32'h4003_0000, 32'h0, 32'h0},
    '{32'h0000_0000, 32'h1000_0000, 32'h4000_0000, 32'h4001_0000,
      32'h4002_0000, 32'h4003_0000, 32'h5000_0000, 32'h6000_0000}};
  localparam logic [31:0] SIZE_T [2][8] = '{
    '{32'h1_0000, 32'h1000_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h0, 32'h0},
    '{32'h1_0000, 32'h1000_0000, 32'h2_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h1000}};

  bus_fabric_if #(.NUM_SLAVES(6)) ifa ();
  bus_fabric_if #(.NUM_SLAVES(8)) ifb ();

  bus_fabric #(.TIMEOUT(TO_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  bus_fabric #(.NUM_SLAVES(8), .SLAVE_BASE(B_BASE), .SLAVE_MASK(B_MASK),
               .WR_ALLOW(8'hFE), .TIMEOUT(TO_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic        tgt = 1'b0;
  logic [31:0] t_addr = '0, t_wdata = '0;
  logic [2:0]  t_size = '0;
  logic        t_rd = 1'b0, t_wr = 1'b0;
  logic [31:0] sdat [8];
  logic [7:0]  mute = '0;
  logic [5:0]  rdy_a;
  logic [7:0]  rdy_b;

  assign ifa.m_addr = t_addr;  assign ifb.m_addr = t_addr;
  assign ifa.m_wdata = t_wdata; assign ifb.m_wdata = t_wdata;
  assign ifa.m_size = t_size;  assign ifb.m_size = t_size;
  assign ifa.m_read = t_rd & ~tgt;  assign ifb.m_read = t_rd & tgt;
  assign ifa.m_write = t_wr & ~tgt; assign ifb.m_write = t_wr & tgt;
  assign ifa.s_ready = rdy_a;  assign ifb.s_ready = rdy_b;
  for (genvar i = 0; i < 8; i++) begin : g_rdata
    if (i < 6) begin : g_a
      assign ifa.s_rdata[i*32 +: 32] = sdat[i];
    end
    assign ifb.s_rdata[i*32 +: 32] = sdat[i];
  end

  // registering slaves: ready one cycle after the strobe is seen, unless muted
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_a <= '0;
      rdy_b <= '0;
    end else begin
      rdy_a <= (ifa.s_read | ifa.s_write) & ~rdy_a & ~mute[5:0];
      rdy_b <= (ifb.s_read | ifb.s_write) & ~rdy_b & ~mute;
    end
  end

  wire        obs_busy  = tgt ? ifb.m_busy : ifa.m_busy;
  wire        obs_err   = tgt ? ifb.m_error : ifa.m_error;
  wire [2:0]  obs_code  = tgt ? ifb.m_err_code : ifa.m_err_code;
  wire [31:0] obs_rdata = tgt ? ifb.m_rdata : ifa.m_rdata;
  wire [7:0]  obs_rd    = tgt ? ifb.s_read : {2'b00, ifa.s_read};
  wire [7:0]  obs_wr    = tgt ? ifb.s_write : {2'b00, ifa.s_write};
  wire [31:0] obs_wdata = tgt ? ifb.s_wdata : ifa.s_wdata;
  wire [2:0]  obs_size  = tgt ? ifb.s_size : ifa.s_size;

  int n_vec = 0;
  int n_miss = 0;
  int step = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_saddr(input logic b, input int idx);
    if (b) return ifb.s_addr[idx*32 +: 32];
    if (idx < 6) return ifa.s_addr[idx*32 +: 32];
    return 32'hFFFF_FFFF;
  endfunction

  // expected slave and cause, from the address ranges and fault priority
  task automatic model(input logic b, input logic [31:0] a, input logic [2:0] sz,
                       input logic rd, input logic wr, output int slv, output logic [2:0] code);
    int n;
    n = b ? 8 : 6;
    slv = -1;
    for (int i = n - 1; i >= 0; i--)
      if ({32'h0, a} >= {32'h0, BASE_T[b][i]} && {32'h0, a} < {32'h0, BASE_T[b][i]} + {32'h0, SIZE_T[b][i]})
        slv = i;
    if (rd && wr) code = 3'd5;
    else if (sz > 3'd2 || (sz == 3'd1 && a % 2 != 0) || (sz == 3'd2 && a % 4 != 0)) code = 3'd2;
    else if (slv < 0) code = 3'd1;
    else if (wr && slv == 0) code = 3'd3;
    else if (mute[slv]) code = 3'd4;
    else code = 3'd0;
  endtask

  task automatic run(input logic b, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] sz, input logic rd, input logic wr);
    int slv, edges, stb_cyc, exp_edges, exp_stb, idx;
    logic [2:0] code;
    logic [7:0] rd_or, wr_or;
    logic [31:0] exp_rd, s_off, s_wd, s_sz;
    logic multi;
    step++;
    model(b, a, sz, rd, wr, slv, code);
    exp_rd    = (code == 3'd0) ? sdat[slv] : 32'hDEAD_BEEF;
    exp_edges = (code == 3'd0) ? 3 : (code == 3'd4) ? (b ? TO_B : TO_A) + 1 : 1;
    exp_stb   = (code == 3'd0) ? 2 : (code == 3'd4) ? (b ? TO_B : TO_A) : 0;
    @(negedge clk);
    tgt = b; t_addr = a; t_wdata = wd; t_size = sz; t_rd = rd; t_wr = wr;
    #1 chk("busy_at_req", {31'h0, obs_busy}, 32'd1);
    edges = 0; stb_cyc = 0; rd_or = '0; wr_or = '0; multi = 1'b0;
    s_off = '0; s_wd = '0; s_sz = '0;
    while (edges < 300) begin
      @(negedge clk);
      edges++;
      if ((obs_rd | obs_wr) != 8'h00) begin
        stb_cyc++;
        rd_or |= obs_rd;
        wr_or |= obs_wr;
        if ($countones(obs_rd | obs_wr) != 1) multi = 1'b1;
        idx = 0;
        for (int i = 0; i < 8; i++) if (obs_rd[i] | obs_wr[i]) idx = i;
        s_off = get_saddr(b, idx);
        s_wd  = obs_wdata;
        s_sz  = {29'h0, obs_size};
      end
      if (!obs_busy) break;
    end
    chk("busy_bound", {31'h0, obs_busy}, 32'd0);
    chk("latency", edges, exp_edges);
    chk("strobe_cycles", stb_cyc, exp_stb);
    chk("strobe_multi", {31'h0, multi}, 32'd0);
    chk("read_strobes", {24'h0, rd_or}, (exp_stb != 0 && rd) ? 32'd1 << slv : 32'd0);
    chk("write_strobes", {24'h0, wr_or}, (exp_stb != 0 && wr) ? 32'd1 << slv : 32'd0);
    if (exp_stb != 0) begin
      chk("s_addr_offset", s_off, a - BASE_T[b][slv]);
      chk("s_size", s_sz, {29'h0, sz});
      if (wr) chk("s_wdata", s_wd, wd);
    end
    chk("m_error", {31'h0, obs_err}, {31'h0, code != 3'd0});
    chk("m_err_code", {29'h0, obs_code}, {29'h0, code});
    chk("m_rdata", obs_rdata, exp_rd);
    t_rd = 1'b0; t_wr = 1'b0;
    @(negedge clk);
    chk("rdata_held", obs_rdata, exp_rd);
    chk("idle_busy", {31'h0, obs_busy}, 32'd0);
  endtask

  initial begin
    logic b;
    int s, r;
    logic [31:0] a;
    logic [2:0] sz;
    for (int i = 0; i < 8; i++) sdat[i] = 32'h1111_0000 + i;
    #12;
    chk("rst_rdata_a", ifa.m_rdata, 32'h0);
    chk("rst_rdata_b", ifb.m_rdata, 32'h0);
    chk("rst_code", {26'h0, ifa.m_err_code, ifb.m_err_code}, 32'h0);
    chk("rst_err_busy", {28'h0, ifa.m_error, ifb.m_error, ifa.m_busy, ifb.m_busy}, 32'h0);
    chk("rst_strobes", {16'h0, ifa.s_read, ifa.s_write, 2'b00}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    sdat[4] = 32'hFEED_FACE;
    run(1'b0, 32'h4002_0010, 32'h0, 3'd2, 1'b1, 1'b0);
    run(1'b0, 32'h1000_1000, 32'h55AA_55AA, 3'd2, 1'b0, 1'b1);
    run(1'b0, 32'h0000_0000, 32'h1234_5678, 3'd2, 1'b0, 1'b1);
    run(1'b0, 32'h8000_0000, 32'h0, 3'd2, 1'b1, 1'b0);
    run(1'b0, 32'h1000_0002, 32'h0, 3'd2, 1'b1, 1'b0);
    run(1'b0, 32'h1000_0000, 32'h0, 3'd3, 1'b1, 1'b0);
    run(1'b0, 32'h1000_0000, 32'h0, 3'd2, 1'b1, 1'b1);
    run(1'b0, 32'h1000_0001, 32'h0, 3'd1, 1'b1, 1'b0);
    run(1'b0, 32'h4003_0003, 32'h0, 3'd0, 1'b1, 1'b0);
    mute[3] = 1'b1;
    run(1'b0, 32'h4001_0000, 32'h0, 3'd2, 1'b1, 1'b0);
    mute[3] = 1'b0;
    run(1'b0, 32'h4000_0004, 32'h0, 3'd2, 1'b1, 1'b0);

    // reset while a muted slave holds the fabric in its access phase
    step++;
    mute[3] = 1'b1;
    @(negedge clk);
    tgt = 1'b0; t_addr = 32'h4001_0040; t_size = 3'd2; t_rd = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_strobe", {26'h0, ifa.s_read}, 32'h8);
    #2 rst_n = 1'b0; t_rd = 1'b0;
    #1;
    chk("mid_rst_strobe", {26'h0, ifa.s_read | ifa.s_write}, 32'h0);
    chk("mid_rst_rdata", ifa.m_rdata, 32'h0);
    chk("mid_rst_status", {28'h0, ifa.m_error, ifa.m_err_code}, 32'h0);
    chk("mid_rst_saddr", ifa.s_addr[3*32 +: 32], 32'h0);
    mute[3] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    sdat[0] = 32'hC0DE_0000;
    run(1'b0, 32'h0000_0100, 32'h0, 3'd2, 1'b1, 1'b0);

    // overlapping 8-slave map
    run(1'b1, 32'h4001_0020, 32'h0, 3'd2, 1'b1, 1'b0);
    run(1'b1, 32'h4000_0008, 32'hA5A5_0001, 3'd2, 1'b0, 1'b1);
    run(1'b1, 32'h5000_0100, 32'h0, 3'd2, 1'b1, 1'b0);
    run(1'b1, 32'h6000_0FFE, 32'h0BAD_F00D, 3'd1, 1'b0, 1'b1);
    run(1'b1, 32'h6000_1000, 32'h0, 3'd2, 1'b1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      b = 1'($urandom_range(0, 1));
      s = $urandom_range(0, b ? 8 : 6);
      for (int i = 0; i < 8; i++) sdat[i] = $urandom;
      if (s == (b ? 8 : 6)) a = 32'h8000_0000 | $urandom;
      else a = BASE_T[b][s] + ($urandom % SIZE_T[b][s] & 32'hFFFF_FFFC);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(0, 3));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      run(b, a, $urandom, sz, r < 6, r == 0 || r >= 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
